// File: rtl/ifetch_pkg.sv
// Shared constants and types for the q1 instruction fetch stage.
// Holds the reset PC default, the canonical NOP and the {pc, instr} FIFO entry.
package ifetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
   localparam logic [31:0] PC_INCR      = 32'h0000_0004;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Instruction fetches are always word aligned; low address bits are dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/ifetch_sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous flush and occupancy count.
// Reads return zero while empty so downstream sees a clean value.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (count_r == {(AW+1){1'b0}});
   assign full      = (count_r == (AW+1)'(DEPTH));
   assign count     = count_r;
   assign do_push_s = push && !full && !flush;
   assign do_pop_s  = pop && !empty && !flush;
   assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

   // Pointer and occupancy tracking; flush empties the FIFO in one edge.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1'b1);
            2'b01:   count_r <= count_r - (AW+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents are only meaningful behind a valid count.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= wdata;
   end

endmodule

// File: rtl/ifetch.sv
// q1 fetch stage: owns the PC, issues credit-limited word fetches, buffers responses
// in a prefetch FIFO and hands {instr, pc, pc+4} to q1q2; redirects flush everything.
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_incr_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc_r;
   logic [CW-1:0] outstanding_r;
   logic [CW-1:0] drop_cnt_r;

   logic [31:0]   pc_next_s;
   logic [CW-1:0] out_next_s;
   logic [CW-1:0] drop_next_s;
   logic [CW-1:0] fifo_count_s;
   logic [CW:0]   inflight_s;
   logic [CW-1:0] pend_keep_s;
   logic [31:0]   rsp_pc_s;
   logic          fifo_empty_s;
   logic          fifo_full_s;
   logic          credit_ok_s;
   logic          req_fire_s;
   logic          rsp_keep_s;
   logic          rsp_drop_s;
   logic          push_s;
   logic          pop_s;
   fetch_entry_t  wr_entry_s;
   fetch_entry_t  head_s;

   // Credit counts both buffered and in-flight words so every response finds a slot.
   assign inflight_s  = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
   assign credit_ok_s = (inflight_s < (CW+1)'(DEPTH));

   assign imem_req_valid_o = !rst && credit_ok_s && !redirect_i;
   assign imem_req_addr_o  = fetch_pc_r;
   assign req_fire_s       = imem_req_valid_o && imem_req_ready_i;

   assign rsp_keep_s = imem_rsp_valid_i && (drop_cnt_r == {CW{1'b0}});
   assign rsp_drop_s = imem_rsp_valid_i && (drop_cnt_r != {CW{1'b0}});

   // Surviving requests are contiguous from the last redirect, so the oldest
   // one's PC is recovered from fetch_pc instead of being stored.
   assign pend_keep_s = outstanding_r - drop_cnt_r;
   assign rsp_pc_s    = fetch_pc_r - {{(30-CW){1'b0}}, pend_keep_s, 2'b00};

   assign push_s     = rsp_keep_s && !redirect_i && !fifo_full_s;
   assign pop_s      = instr_valid_o && instr_ready_i;
   assign wr_entry_s = '{pc: rsp_pc_s, instr: imem_rsp_data_i};

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_i),
      .push  (push_s),
      .wdata (wr_entry_s),
      .pop   (pop_s),
      .rdata (head_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s),
      .count (fifo_count_s)
   );

   assign instr_valid_o = !fifo_empty_s && !redirect_i;
   assign instr_o       = head_s.instr;
   assign pc_o          = head_s.pc;
   assign pc_incr_o     = head_s.pc + PC_INCR;

   // Next-state for PC, outstanding and drop counters.
   always_comb begin
      out_next_s  = outstanding_r;
      drop_next_s = drop_cnt_r;
      pc_next_s   = fetch_pc_r;
      case ({req_fire_s, imem_rsp_valid_i})
         2'b10:   out_next_s = outstanding_r + CW'(1'b1);
         2'b01:   out_next_s = outstanding_r - CW'(1'b1);
         default: out_next_s = outstanding_r;
      endcase
      if (redirect_i) begin
         // Every request still unanswered after this cycle belongs to the old path.
         drop_next_s = out_next_s;
         pc_next_s   = align_pc(redirect_pc_i);
      end else begin
         drop_next_s = rsp_drop_s ? (drop_cnt_r - CW'(1'b1)) : drop_cnt_r;
         pc_next_s   = req_fire_s ? (fetch_pc_r + PC_INCR) : fetch_pc_r;
      end
   end

   // Fetch state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_r    <= RESET_PC;
         outstanding_r <= {CW{1'b0}};
         drop_cnt_r    <= {CW{1'b0}};
      end else begin
         fetch_pc_r    <= pc_next_s;
         outstanding_r <= out_next_s;
         drop_cnt_r    <= drop_next_s;
      end
   end

endmodule
